// File: rtl/ac_sequencer_if.sv
// Bus bundle between the accumulator-CPU sequencer, its instruction memory and ctrlunit.
// The master side is the sequencer; the slave side is the memory/ctrlunit/ALU environment.
interface ac_sequencer_if #(
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5
);
    localparam int DATA_W = OP_W + ADDR_W;

    logic              en_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [OP_W-1:0]   op_o;
    logic [ADDR_W-1:0] operand_o;
    logic [1:0]        flags_o;
    logic              jmp_i;
    logic              wf_i;
    logic [1:0]        alu_flags_i;
    logic              exec_o;
    logic [ADDR_W-1:0] pc_o;

    modport master (
        input  en_i, mem_ack_i, mem_rdata_i, jmp_i, wf_i, alu_flags_i,
        output mem_req_o, mem_addr_o, op_o, operand_o, flags_o, exec_o, pc_o
    );

    modport slave (
        output en_i, mem_ack_i, mem_rdata_i, jmp_i, wf_i, alu_flags_i,
        input  mem_req_o, mem_addr_o, op_o, operand_o, flags_o, exec_o, pc_o
    );
endinterface

// File: rtl/ac_sequencer.sv
// Instruction sequencer for the accumulator CPU: fetches over req/ack, holds PC/IR/flags
// and issues a one-cycle exec strobe once ctrlunit has settled on the decoded opcode.
module ac_sequencer #(
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ac_sequencer_if.master       bus
);
    localparam int DATA_W = OP_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] ir_r;
    logic [1:0]        flags_r;
    logic              mem_req_r;
    logic              exec_r;
    logic [ADDR_W-1:0] pc_next_s;

    // Next PC taken at the end of EXEC: jump target or sequential increment (wraps naturally).
    always_comb begin
        pc_next_s = pc_r;
        if (bus.jmp_i) begin
            pc_next_s = ir_r[ADDR_W-1:0];
        end else begin
            pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer FSM; every output is a register so nothing combinational leaks from the inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            pc_r      <= {ADDR_W{1'b0}};
            ir_r      <= {DATA_W{1'b0}};
            flags_r   <= 2'b00;
            mem_req_r <= 1'b0;
            exec_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    exec_r <= 1'b0;
                    if (bus.en_i) begin
                        state_r   <= ST_FETCH;
                        mem_req_r <= 1'b1;
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Address comes straight from pc_r, which only moves in EXEC, so it is stable here.
                    if (bus.mem_ack_i) begin
                        ir_r      <= bus.mem_rdata_i;
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DECODE;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    exec_r  <= 1'b1;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    exec_r <= 1'b0;
                    pc_r   <= pc_next_s;
                    if (bus.wf_i) begin
                        flags_r <= bus.alu_flags_i;
                    end else begin
                        flags_r <= flags_r;
                    end
                    if (bus.en_i) begin
                        state_r   <= ST_FETCH;
                        mem_req_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    exec_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_o  = mem_req_r;
    assign bus.mem_addr_o = pc_r;
    assign bus.op_o       = ir_r[DATA_W-1:ADDR_W];
    assign bus.operand_o  = ir_r[ADDR_W-1:0];
    assign bus.flags_o    = flags_r;
    assign bus.exec_o     = exec_r;
    assign bus.pc_o       = pc_r;
endmodule

// File: tb/tb_ac_sequencer.sv
// Directed bench for ac_sequencer: hand-computed expectations for fetch, jump, wrap,
// flag commit, delayed ack, reset mid-fetch and en_i drop.
module tb_ac_sequencer;
    logic clk_i;
    logic rst_ni;
    int   err_cnt;
    int   chk_cnt;

    ac_sequencer_if #(.OP_W(3), .ADDR_W(5)) bus ();

    ac_sequencer #(.OP_W(3), .ADDR_W(5)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start in FETCH: ack a word, run DECODE and EXEC with the given ctrlunit decisions.
    task automatic run_instr(input logic [7:0] word, input logic j, input logic w,
                             input logic [1:0] af, input string tag);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = word;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 8'h00;
        chk({tag, "_dec_op"}, 32'(bus.op_o), 32'(word[7:5]));
        chk({tag, "_dec_operand"}, 32'(bus.operand_o), 32'(word[4:0]));
        chk({tag, "_dec_exec"}, 32'(bus.exec_o), 32'd0);
        bus.jmp_i       = j;
        bus.wf_i        = w;
        bus.alu_flags_i = af;
        tick();
        chk({tag, "_exec"}, 32'(bus.exec_o), 32'd1);
        tick();
        bus.jmp_i       = 1'b0;
        bus.wf_i        = 1'b0;
        bus.alu_flags_i = 2'b00;
        chk({tag, "_exec_off"}, 32'(bus.exec_o), 32'd0);
    endtask

    initial begin
        err_cnt         = 0;
        chk_cnt         = 0;
        rst_ni          = 1'b0;
        bus.en_i        = 1'b0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 8'h00;
        bus.jmp_i       = 1'b0;
        bus.wf_i        = 1'b0;
        bus.alu_flags_i = 2'b00;
        tick();
        tick();
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_exec", 32'(bus.exec_o), 32'd0);
        chk("rst_pc", 32'(bus.pc_o), 32'd0);
        chk("rst_flags", 32'(bus.flags_o), 32'd0);
        chk("rst_op", 32'(bus.op_o), 32'd0);

        // 1: reset in the middle of a fetch, then a late ack must be ignored
        rst_ni   = 1'b1;
        bus.en_i = 1'b1;
        tick();
        tick();
        chk("t1_req_before", 32'(bus.mem_req_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t1_req_async", 32'(bus.mem_req_o), 32'd0);
        chk("t1_pc", 32'(bus.pc_o), 32'd0);
        chk("t1_flags", 32'(bus.flags_o), 32'd0);
        chk("t1_exec", 32'(bus.exec_o), 32'd0);
        bus.en_i        = 1'b0;
        tick();
        rst_ni          = 1'b1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 8'hE7;
        tick();
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 8'h00;
        chk("t1_late_ack_req", 32'(bus.mem_req_o), 32'd0);
        chk("t1_late_ack_op", 32'(bus.op_o), 32'd0);
        chk("t1_late_ack_exec", 32'(bus.exec_o), 32'd0);

        // 2: LDA 5 from address 0
        bus.en_i = 1'b1;
        tick();
        chk("t2_req", 32'(bus.mem_req_o), 32'd1);
        chk("t2_addr", 32'(bus.mem_addr_o), 32'd0);
        run_instr(8'h45, 1'b0, 1'b0, 2'b00, "t2");
        chk("t2_pc", 32'(bus.pc_o), 32'd1);
        chk("t2_addr_next", 32'(bus.mem_addr_o), 32'd1);
        chk("t2_req_next", 32'(bus.mem_req_o), 32'd1);

        // 3: JMP 26, then jump to 31, then sequential wrap to 0
        run_instr(8'h9A, 1'b1, 1'b0, 2'b00, "t3j");
        chk("t3_pc_jmp", 32'(bus.pc_o), 32'd26);
        chk("t3_addr_jmp", 32'(bus.mem_addr_o), 32'd26);
        run_instr(8'hFF, 1'b1, 1'b0, 2'b00, "t3k");
        chk("t3_pc_31", 32'(bus.pc_o), 32'd31);
        run_instr(8'h00, 1'b0, 1'b0, 2'b00, "t3w");
        chk("t3_pc_wrap", 32'(bus.pc_o), 32'd0);

        // 4: flags committed only with wf_i
        run_instr(8'h20, 1'b0, 1'b1, 2'b01, "t4a");
        chk("t4_flags_set", 32'(bus.flags_o), 32'd1);
        chk("t4_pc", 32'(bus.pc_o), 32'd1);
        run_instr(8'h21, 1'b0, 1'b0, 2'b10, "t4b");
        chk("t4_flags_hold", 32'(bus.flags_o), 32'd1);
        chk("t4_pc2", 32'(bus.pc_o), 32'd2);

        // 5: ack delayed three cycles; rdata noise before ack must not reach IR
        bus.mem_rdata_i = 8'hE7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_wait_req", 32'(bus.mem_req_o), 32'd1);
            chk("t5_wait_addr", 32'(bus.mem_addr_o), 32'd2);
            chk("t5_wait_exec", 32'(bus.exec_o), 32'd0);
            chk("t5_wait_op", 32'(bus.op_o), 32'd1);
        end
        run_instr(8'h63, 1'b0, 1'b0, 2'b00, "t5");
        chk("t5_pc", 32'(bus.pc_o), 32'd3);

        // 6: en_i dropped during fetch; the instruction still completes, then IDLE
        bus.en_i = 1'b0;
        tick();
        chk("t6_req_still", 32'(bus.mem_req_o), 32'd1);
        run_instr(8'hA4, 1'b0, 1'b0, 2'b00, "t6");
        chk("t6_pc", 32'(bus.pc_o), 32'd4);
        chk("t6_req_idle", 32'(bus.mem_req_o), 32'd0);
        tick();
        tick();
        chk("t6_idle_req", 32'(bus.mem_req_o), 32'd0);
        chk("t6_idle_exec", 32'(bus.exec_o), 32'd0);
        chk("t6_idle_pc", 32'(bus.pc_o), 32'd4);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
